// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, scrolls, retires and scores a fixed pool of obstacle slots
// Ports: clk, reset (sync, active-high), frame_tick (per-frame pulse), start/collision (game levels);
// obs_active/obs_x/obs_yBot/obs_yTop packed per slot, score_pulse (one cycle per scoring tick),
// run_state (0 IDLE, 1 RUN, 2 HALT).
module obstacle_scheduler #(
    parameter int NUM_SLOTS = 3,
    parameter int SPEED = 2,
    parameter int SPAWN_FRAMES = 120,
    parameter int GAP = 140,
    parameter int MIN_PIPE = 40,
    parameter int BIRD_X = 160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int SCREEN_WIDTH = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int OBSTACLE_WIDTH = 80
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      start,
    input  logic                      collision,
    output logic [NUM_SLOTS-1:0]      obs_active,
    output logic [NUM_SLOTS*10-1:0]   obs_x,
    output logic [NUM_SLOTS*9-1:0]    obs_yBot,
    output logic [NUM_SLOTS*9-1:0]    obs_yTop,
    output logic                      score_pulse,
    output logic [1:0]                run_state
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2;
    localparam logic [9:0] SW = 10'(SCREEN_WIDTH);
    localparam logic [9:0] SPD = 10'(SPEED);
    localparam logic [9:0] SF_LAST = 10'(SPAWN_FRAMES - 1);
    localparam logic [10:0] OW = 11'(OBSTACLE_WIDTH);
    localparam logic [10:0] BX = 11'(BIRD_X);
    localparam logic [8:0] MP = 9'(MIN_PIPE);
    localparam logic [8:0] OPEN = 9'(SCREEN_HEIGHT - GAP);

    logic [1:0] state, state_nxt;
    logic [15:0] lfsr;
    logic [9:0] x [NUM_SLOTS];
    logic [8:0] ybot [NUM_SLOTS];
    logic [8:0] ytop [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active, scored, free, sel, score_hit;
    logic [9:0] spawn_cnt;
    logic spawn_pending, go, clear, wrap, want;
    logic [8:0] ytop_new, ybot_new;

    assign go = state == RUN && frame_tick && !collision;
    assign clear = start && state != RUN;
    assign wrap = spawn_cnt == SF_LAST;
    assign want = spawn_pending || wrap;
    assign free = ~active;
    // lowest set bit of the free mask picks the spawn slot
    assign sel = free & (~free + 1'b1);
    assign ytop_new = MP + {1'b0, lfsr[7:0]};
    assign ybot_new = OPEN - ytop_new;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == RUN ? (collision ? HALT : RUN) : (start ? RUN : state);
    end

    always_comb begin
        run_state = state;
    end

    // Galois form of x^16+x^14+x^13+x^11+1, free-running in every state
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // scoring is judged on the post-move position of slots that are not retiring
    always_comb begin
        score_hit = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            score_hit[i] = active[i] && !scored[i] && x[i] >= SPD && ({1'b0, x[i] - SPD} + OW) < BX;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            active <= '0;
            scored <= '0;
            spawn_pending <= 1'b0;
            spawn_cnt <= reset ? 10'd0 : SF_LAST;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x[i] <= SW;
                ybot[i] <= '0;
                ytop[i] <= '0;
            end
        end else if (go) begin
            spawn_cnt <= wrap ? 10'd0 : spawn_cnt + 10'd1;
            spawn_pending <= want && ~|free;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (want && sel[i]) begin
                    active[i] <= 1'b1;
                    scored[i] <= 1'b0;
                    x[i] <= SW;
                    ytop[i] <= ytop_new;
                    ybot[i] <= ybot_new;
                end else if (active[i]) begin
                    if (x[i] >= SPD) begin
                        x[i] <= x[i] - SPD;
                        if (score_hit[i]) scored[i] <= 1'b1;
                    end else begin
                        active[i] <= 1'b0;
                        x[i] <= SW;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) score_pulse <= 1'b0;
        else score_pulse <= go && |score_hit;
    end

    always_comb begin
        obs_active = active;
        obs_x = '0;
        obs_yBot = '0;
        obs_yTop = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            obs_x[10*i +: 10] = x[i];
            obs_yBot[9*i +: 9] = ybot[i];
            obs_yTop[9*i +: 9] = ytop[i];
        end
    end
endmodule
